// File: rtl/accelerator_for_conv2d.sv
// Pipelined single-output 2-D convolution MAC engine.
// Each cycle one FILTER_SIZE x FILTER_SIZE filter window and one image patch
// of the same size are sampled; their dot product appears on result three
// rising edges later. There is no handshake: one window is accepted every
// cycle, and results leave in the same order.
//
// Pipeline:
//   S1: prod_q    - every element-wise product, 2*DATA_WIDTH bits wide
//   S2: row_sum_q - one sum per filter row
//   S3: result    - total of the row sums
//
// Row sums and the total are held at RESULT_WIDTH bits. With a legal
// RESULT_WIDTH nothing overflows. With a narrower RESULT_WIDTH every
// partial sum wraps modulo 2^RESULT_WIDTH, so the final value is the true sum
// modulo 2^RESULT_WIDTH, without saturation.

package ai_accelerator_pkg;
  parameter int DATA_WIDTH   = 8;
  parameter int FILTER_SIZE  = 3;
  parameter int RESULT_WIDTH = 32;
endpackage

module accelerator_for_conv2d
  import ai_accelerator_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   filter_matrix [FILTER_SIZE][FILTER_SIZE],
  input  logic [DATA_WIDTH-1:0]   image_patch   [FILTER_SIZE][FILTER_SIZE],
  output logic [RESULT_WIDTH-1:0] result
);

  localparam int PROD_W = 2 * DATA_WIDTH;

  // Stage registers. All of them clear asynchronously, so a reset asserted
  // mid-stream discards every window in flight at once.
  logic [PROD_W-1:0]       prod_q    [FILTER_SIZE][FILTER_SIZE];
  logic [RESULT_WIDTH-1:0] row_sum_d [FILTER_SIZE];
  logic [RESULT_WIDTH-1:0] row_sum_q [FILTER_SIZE];
  logic [RESULT_WIDTH-1:0] total_d;

  // S1: register the zero-extended unsigned product of each element pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < FILTER_SIZE; r++) begin
        for (int c = 0; c < FILTER_SIZE; c++) begin
          prod_q[r][c] <= '0;
        end
      end
    end else begin
      for (int r = 0; r < FILTER_SIZE; r++) begin
        for (int c = 0; c < FILTER_SIZE; c++) begin
          prod_q[r][c] <= PROD_W'(filter_matrix[r][c]) * PROD_W'(image_patch[r][c]);
        end
      end
    end
  end

  // S2 adder: sum the products of each row (products zero-extended to result width).
  always_comb begin
    for (int r = 0; r < FILTER_SIZE; r++) begin
      row_sum_d[r] = '0;
    end
    for (int r = 0; r < FILTER_SIZE; r++) begin
      for (int c = 0; c < FILTER_SIZE; c++) begin
        row_sum_d[r] = row_sum_d[r] + RESULT_WIDTH'(prod_q[r][c]);
      end
    end
  end

  // S2: register the per-row sums.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < FILTER_SIZE; r++) begin
        row_sum_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < FILTER_SIZE; r++) begin
        row_sum_q[r] <= row_sum_d[r];
      end
    end
  end

  // S3 adder: total of all row sums.
  always_comb begin
    total_d = '0;
    for (int r = 0; r < FILTER_SIZE; r++) begin
      total_d = total_d + row_sum_q[r];
    end
  end

  // S3: register the final sum. result comes straight from this flop, so no
  // combinational path runs from the inputs to result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
    end else begin
      result <= total_d;
    end
  end

endmodule

// File: tb/tb_accelerator_for_conv2d.sv
// Self-checking bench for accelerator_for_conv2d.
// Inputs change on the falling edge and result is sampled on the falling
// edge, away from the active rising edge.
module tb_accelerator_for_conv2d;
  import ai_accelerator_pkg::*;

  localparam int DW = DATA_WIDTH;
  localparam int FS = FILTER_SIZE;
  localparam int RW = RESULT_WIDTH;

  logic          clk;
  logic          rst;
  logic [DW-1:0] f_win [FS][FS];
  logic [DW-1:0] i_win [FS][FS];
  logic [RW-1:0] result;

  int checks;
  int failures;

  logic [RW-1:0] exp_q[$];

  accelerator_for_conv2d dut (
    .clk           (clk),
    .rst           (rst),
    .filter_matrix (f_win),
    .image_patch   (i_win),
    .result        (result)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the dot product of the two windows, using wide integer
  // arithmetic, taken modulo 2^RW.
  function automatic logic [RW-1:0] conv_model();
    longint s;
    s = 0;
    for (int r = 0; r < FS; r++) begin
      for (int c = 0; c < FS; c++) begin
        s = s + longint'(f_win[r][c]) * longint'(i_win[r][c]);
      end
    end
    return s[RW-1:0];
  endfunction

  // Driver tasks
  task automatic set_uniform(input int fv, input int iv);
    for (int r = 0; r < FS; r++) begin
      for (int c = 0; c < FS; c++) begin
        f_win[r][c] = DW'(fv);
        i_win[r][c] = DW'(iv);
      end
    end
  endtask

  task automatic set_single();
    set_uniform(0, 0);
    f_win[0][0] = DW'(1);
    i_win[0][0] = DW'(1);
  endtask

  task automatic set_random();
    for (int r = 0; r < FS; r++) begin
      for (int c = 0; c < FS; c++) begin
        f_win[r][c] = DW'($urandom_range(0, (1 << DW) - 1));
        i_win[r][c] = DW'($urandom_range(0, (1 << DW) - 1));
      end
    end
  endtask

  // Assert reset for two falling edges with zero inputs. Release it on a
  // falling edge and return there.
  task automatic do_reset();
    set_uniform(0, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set_uniform(0, 0);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (result !== '0) begin
        failures++;
        $display("FAIL reset_hold: result=%0d expected=0", result);
      end
    end
    rst = 1'b0;
    for (int e = 0; e < 4; e++) begin
      @(negedge clk);
      checks++;
      if (result !== '0) begin
        failures++;
        $display("FAIL reset_release edge%0d: result=%0d expected=0", e + 1, result);
      end
    end
  endtask

  task automatic test_single();
    logic [RW-1:0] exp;
    do_reset();
    set_single();
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      exp = (e >= 3) ? RW'(1) : RW'(0);
      checks++;
      if (result !== exp) begin
        failures++;
        $display("FAIL single edge%0d: result=%0d expected=%0d", e, result, exp);
      end
    end
  endtask

  task automatic test_uniform_windows();
    int            fv [3] = '{1, 2, 255};
    int            iv [3] = '{1, 3, 255};
    logic [RW-1:0] ev [3];
    ev[0] = RW'(9);
    ev[1] = RW'(54);
    ev[2] = RW'(585225);
    for (int k = 0; k < 3; k++) begin
      do_reset();
      set_uniform(fv[k], iv[k]);
      repeat (2) @(negedge clk);
      checks++;
      if (result !== '0) begin
        failures++;
        $display("FAIL uniform%0d_latency: result=%0d expected=0", k, result);
      end
      for (int e = 3; e <= 5; e++) begin
        @(negedge clk);
        checks++;
        if (result !== ev[k]) begin
          failures++;
          $display("FAIL uniform%0d edge%0d: result=%0d expected=%0d", k, e, result, ev[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [RW-1:0] ev [6];
    ev[0] = RW'(0);
    ev[1] = RW'(0);
    ev[2] = RW'(1);
    ev[3] = RW'(9);
    ev[4] = RW'(54);
    ev[5] = RW'(0);
    do_reset();
    for (int k = 0; k < 6; k++) begin
      case (k)
        0:       set_single();
        1:       set_uniform(1, 1);
        2:       set_uniform(2, 3);
        default: set_uniform(0, 0);
      endcase
      @(negedge clk);
      checks++;
      if (result !== ev[k]) begin
        failures++;
        $display("FAIL back_to_back edge%0d: result=%0d expected=%0d", k + 1, result, ev[k]);
      end
    end
  endtask

  // Random windows every cycle. The scoreboard queue is primed with the three
  // zero results that the pipeline holds just after reset.
  task automatic run_random(input int n, input string tag);
    logic [RW-1:0] exp;
    exp_q.delete();
    repeat (3) exp_q.push_back('0);
    for (int k = 0; k < n + 3; k++) begin
      exp = exp_q.pop_front();
      checks++;
      if (result !== exp) begin
        failures++;
        $display("FAIL %s cycle%0d: result=%0d expected=%0d", tag, k, result, exp);
      end
      if (k < n) set_random();
      else       set_uniform(0, 0);
      exp_q.push_back(conv_model());
      @(negedge clk);
    end
  endtask

  task automatic test_random_stream();
    do_reset();
    run_random(200, "random_stream");
  endtask

  task automatic test_mid_reset();
    do_reset();
    // Fill the pipeline with non-zero windows.
    for (int k = 0; k < 5; k++) begin
      set_uniform(200 + k, 100 + k);
      @(negedge clk);
    end
    checks++;
    if (result !== RW'(9 * 202 * 102)) begin
      failures++;
      $display("FAIL mid_reset_prefill: result=%0d expected=%0d", result, 9 * 202 * 102);
    end
    // Assert reset between clock edges; result must clear without a clock.
    #2 rst = 1'b1;
    #1;
    checks++;
    if (result !== '0) begin
      failures++;
      $display("FAIL mid_reset_async: result=%0d expected=0", result);
    end
    set_random();
    @(negedge clk);
    checks++;
    if (result !== '0) begin
      failures++;
      $display("FAIL mid_reset_held: result=%0d expected=0", result);
    end
    rst = 1'b0;
    // After release, only the new windows may appear, preceded by zeros.
    run_random(12, "post_reset");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    set_uniform(0, 0);
    test_reset();
    test_single();
    test_uniform_windows();
    test_back_to_back();
    test_random_stream();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
